// File: rtl/hazard_ctrl_unit.sv
// Hazard/redirect controller: load-use stall, busy hold, branch redirect, stall watchdog, perf counters.
// Controls are combinational, valid the same cycle; busy EX holds IF/ID by stalling and has priority over redirect.
module hazard_ctrl_unit #(
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0010,
    parameter int          WDOG_LIMIT = 64,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_busy,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_tar,
    output logic             stall,
    output logic             jump,
    output logic [31:0]      jmp_tar,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             trap_misalign,
    output logic             hang_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LU    = 2'd1,
        BUSY  = 2'd2,
        REDIR = 2'd3
    } state_t;

    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    state_t          state;
    state_t          state_nxt;
    logic            lu;
    logic            mis;
    logic [WD_W-1:0] wdog_cnt;

    assign lu  = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mis = ex_branch_taken && (ex_branch_tar[1:0] != 2'b00);

    assign ctrl_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Being in LU masks the load-use term so a held hazard stalls only once.
    always_comb begin
        state_nxt = RUN;
        if (ex_busy) begin
            state_nxt = BUSY;
        end else if (ex_branch_taken) begin
            state_nxt = REDIR;
        end else if (lu && (state != LU)) begin
            state_nxt = LU;
        end
    end

    always_comb begin
        stall         = 1'b0;
        jump          = 1'b0;
        jmp_tar       = 32'd0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        trap_misalign = 1'b0;
        if (reset) begin
            stall = 1'b0;
        end else if (ex_busy) begin
            stall = 1'b1;
        end else if (mis) begin
            jump          = 1'b1;
            jmp_tar       = TRAP_VEC;
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
            trap_misalign = 1'b1;
        end else if (ex_branch_taken) begin
            jump       = 1'b1;
            jmp_tar    = ex_branch_tar;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (lu && (state != LU)) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
        end
    end

    // Watchdog saturates at the limit; hang_err stays set until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            hang_err <= 1'b0;
        end else if (!stall) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WD_W'(WDOG_LIMIT)) begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
            if (wdog_cnt == WD_W'(WDOG_LIMIT - 1)) begin
                hang_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (jump && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; a second 4-bit-counter instance shares the stimulus for saturation.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_busy, ex_branch_taken;
    logic [31:0] ex_branch_tar;

    logic        stall, jump, flush_ifid, flush_idex, trap_misalign, hang_err;
    logic [31:0] jmp_tar;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt, redirect_cnt;

    logic        s_stall, s_jump, s_flush_ifid, s_flush_idex, s_trap, s_hang;
    logic [31:0] s_jmp_tar;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_redirect_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit u_dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_busy(ex_busy),
        .ex_branch_taken(ex_branch_taken), .ex_branch_tar(ex_branch_tar),
        .stall(stall), .jump(jump), .jmp_tar(jmp_tar),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .trap_misalign(trap_misalign),
        .hang_err(hang_err), .ctrl_state(ctrl_state),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    hazard_ctrl_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_busy(ex_busy),
        .ex_branch_taken(ex_branch_taken), .ex_branch_tar(ex_branch_tar),
        .stall(s_stall), .jump(s_jump), .jmp_tar(s_jmp_tar),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .trap_misalign(s_trap),
        .hang_err(s_hang), .ctrl_state(s_state),
        .stall_cnt(s_stall_cnt), .redirect_cnt(s_redirect_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_busy = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_tar = 32'd0;
    endtask

    task automatic chk_ctrl(input string tag, input logic st, input logic jp, input logic [31:0] tar,
                            input logic fi, input logic fe, input logic tm);
        chk({tag, ".ctrl"}, {26'd0, st, jp, fi, fe, tm, 1'b0}, {26'd0, st, jp, fi, fe, tm, 1'b0} ^
            {26'd0, stall ^ st, jump ^ jp, flush_ifid ^ fi, flush_idex ^ fe, trap_misalign ^ tm, 1'b0});
        chk({tag, ".tar"}, jmp_tar, tar);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Reset dominates busy and taken branch
        ex_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_tar = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.stall", {31'd0, stall}, 32'd0);
            chk("rst.jump", {31'd0, jump}, 32'd0);
            chk("rst.tar", jmp_tar, 32'd0);
            chk("rst.flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
            chk("rst.trap", {31'd0, trap_misalign}, 32'd0);
        end
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rst.state", {30'd0, ctrl_state}, 32'd0);
        chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst.redirect_cnt", {16'd0, redirect_cnt}, 32'd0);
        chk("rst.hang", {31'd0, hang_err}, 32'd0);

        // Load-use on rs1, held for two cycles
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        chk_ctrl("lu1", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lu2.state", {30'd0, ctrl_state}, 32'd1);
        chk("lu2.stall", {31'd0, stall}, 32'd0);
        chk("lu2.flush_idex", {31'd0, flush_idex}, 32'd0);
        chk("lu2.stall_cnt", {16'd0, stall_cnt}, 32'd1);
        tick();
        chk("lu3.state", {30'd0, ctrl_state}, 32'd0);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        chk("lu.x0.stall", {31'd0, stall}, 32'd0);

        // Load-use on rs2 only; rs1 disabled even though it matches
        id_use_rs1 = 1'b0; id_rs1 = 5'd7; id_use_rs2 = 1'b1; id_rs2 = 5'd7; ex_rd = 5'd7;
        #1;
        chk_ctrl("lu.rs2", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        id_use_rs2 = 1'b0;
        #1;
        chk("lu.nouse.stall", {31'd0, stall}, 32'd0);
        id_use_rs2 = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("lu.rs2.stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // Taken branch with a simultaneous wrong-path load-use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        ex_branch_taken = 1'b1; ex_branch_tar = 32'h0000_0100;
        #1;
        chk_ctrl("br", 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        tick();
        chk("br.redirect_cnt", {16'd0, redirect_cnt}, 32'd1);
        chk("br.state", {30'd0, ctrl_state}, 32'd3);
        ex_branch_taken = 1'b0;
        #1;
        chk("br.lu_after.stall", {31'd0, stall}, 32'd1);
        clear_inputs();

        // Misaligned target goes to the trap vector for one cycle
        ex_branch_taken = 1'b1; ex_branch_tar = 32'h0000_0102;
        #1;
        chk_ctrl("mis", 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk_ctrl("mis.after", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mis.redirect_cnt", {16'd0, redirect_cnt}, 32'd2);

        // Watchdog: 64 consecutive busy cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex_busy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk("wd.stall", {31'd0, stall}, 32'd1);
            if (i == 63) chk("wd.hang_early", {31'd0, hang_err}, 32'd0);
            tick();
        end
        ex_busy = 1'b0;
        #1;
        chk("wd.hang", {31'd0, hang_err}, 32'd1);
        chk("wd.stall_cnt", {16'd0, stall_cnt}, 32'd64);
        chk("wd.state", {30'd0, ctrl_state}, 32'd2);
        chk("wd.stall_off", {31'd0, stall}, 32'd0);
        tick();
        chk("wd.hang_sticky", {31'd0, hang_err}, 32'd1);

        // Busy outranks a taken branch
        ex_busy = 1'b1; ex_branch_taken = 1'b1; ex_branch_tar = 32'h0000_0102;
        #1;
        chk_ctrl("busy_br", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Saturation of the 4-bit redirect counter
        reset = 1'b1;
        tick();
        chk("sat.hang_clr", {31'd0, hang_err}, 32'd0);
        reset = 1'b0;
        ex_branch_taken = 1'b1; ex_branch_tar = 32'h0000_0200;
        repeat (20) tick();
        chk("sat.redirect_cnt4", {28'd0, s_redirect_cnt}, 32'd15);
        chk("sat.redirect_cnt16", {16'd0, redirect_cnt}, 32'd20);
        tick();
        chk("sat.hold", {28'd0, s_redirect_cnt}, 32'd15);
        ex_branch_taken = 1'b0;
        reset = 1'b1;
        tick();
        chk("sat.reset", {28'd0, s_redirect_cnt}, 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline hazard and redirect controller for the 5-stage RISC-V core. It drives the `stall`, `jump` and `jmp_tar` inputs of `pc_register`, plus the IF/ID and ID/EX flush controls.
- Inputs come from the ID stage (source registers), the EX stage (load destination, busy multi-cycle unit, resolved branch/jump) and the core clock.
- A small FSM prevents load-use livelock.
- It also keeps a stall watchdog and saturating performance counters.

Parameters:
TRAP_VEC, 32'h0000_0010, redirect target for a misaligned taken branch/jump
WDOG_LIMIT, 64, consecutive stall cycles before hang_err sets
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_busy  in  1  multi-cycle EX unit not done; EX must hold
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
ex_branch_tar  in  32  resolved target address
stall  out  1  hold PC and IF/ID (to pc_register.stall)
jump  out  1  load jmp_tar into PC (to pc_register.jump)
jmp_tar  out  32  redirect address (to pc_register.jmp_tar)
flush_ifid  out  1  clear IF/ID to bubble at next edge
flush_idex  out  1  clear ID/EX to bubble at next edge
trap_misalign  out  1  one-cycle flag: misaligned target redirected to TRAP_VEC
hang_err  out  1  sticky watchdog error
ctrl_state  out  2  registered FSM state
stall_cnt  out  CNT_W  saturating count of stall cycles
redirect_cnt  out  CNT_W  saturating count of jump cycles

Behaviour:
Definitions:
- lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- mis = ex_branch_taken & (ex_branch_tar[1:0] != 0).

Control outputs are combinational from the inputs and ctrl_state, valid in the same cycle, and consumed at the next edge. Per-cycle decode uses the first matching row:
1. reset=1: stall, jump, flush_ifid, flush_idex, trap_misalign = 0; jmp_tar = 0.
2. ex_busy: stall=1, jump=0, flushes=0. Branch and lu are ignored this cycle.
3. mis: jump=1, jmp_tar=TRAP_VEC, flush_ifid=1, flush_idex=1, trap_misalign=1, stall=0.
4. ex_branch_taken: jump=1, jmp_tar=ex_branch_tar, flush_ifid=1, flush_idex=1, stall=0. A simultaneous lu is wrong-path and gets no stall.
5. lu & ctrl_state != LU: stall=1, flush_idex=1 (bubble into EX), flush_ifid=0, jump=0.
6. Otherwise: all 0.
- jmp_tar = 0 whenever jump = 0.
- trap_misalign is 0 whenever mis = 0.

FSM (ctrl_state), registered; next state = row taken this cycle:
- RUN=0: rows 5-fall-through. Also the next state after a row-5 match when ctrl_state is already LU.
- LU=1: row 5.
- BUSY=2: row 2.
- REDIR=3: rows 3/4.
- Reset → RUN.
- While in LU, lu is ignored, so a load-use stall lasts exactly 1 cycle even if the inputs are held.

Watchdog:
- Counter counts consecutive cycles with stall=1 and clears on any cycle with stall=0.
- When it reaches WDOG_LIMIT, hang_err is set at that edge and holds until reset.
- hang_err does not affect the control outputs.

Counters:
- stall_cnt increments at each edge where stall=1; redirect_cnt increments at each edge where jump=1.
- Both saturate at all-ones, are registered (visible the next cycle), and reset to 0.

Reset (synchronous), including mid-stall or mid-busy:
- At the edge: ctrl_state=RUN; watchdog, hang_err, stall_cnt, redirect_cnt = 0.
- Control outputs are forced 0 while reset=1.

Test Plan:
- Reset: reset=1 for 3 cycles with ex_busy=1 and ex_branch_taken=1 → all control outputs 0; after release counters=0, ctrl_state=0, hang_err=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, held 2 cycles → cycle 1: stall=1, flush_idex=1, ctrl_state→1. Cycle 2: stall=0, flush_idex=0. stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Taken branch: ex_branch_taken=1, ex_branch_tar=0x0000_0100, lu also true → same cycle jump=1, jmp_tar=0x100, flush_ifid=flush_idex=1, stall=0; next cycle redirect_cnt=1, ctrl_state=3.
- Misaligned: ex_branch_tar=0x0000_0102, taken → jump=1, jmp_tar=0x0000_0010, trap_misalign=1 for exactly that cycle.
- Watchdog: ex_busy=1 for 64 cycles, then 0 → stall=1 each busy cycle; hang_err=1 after the 64th edge and still 1 after busy drops; stall_cnt=64.
- Saturation (CNT_W=4): 20 taken-branch cycles → redirect_cnt=15 and holds; a reset clears it to 0.
